instr_cache_assoc: RTL and testbench
====================================

Name: instr_cache_assoc

Overview:
- Parametrised, read-only, N-way set-associative instruction cache.
- Sits between the fetch stage and the line-wide physical memory arbiter port.
- Successor to the fixed single-configuration I-cache. Adds configurable ways, sets and line width, a whole-cache flush, invalid-first/round-robin replacement, and saturating hit/miss counters.

Parameters:
- WAYS, 2, associativity. Power of two, 1..8.
- SETS, 8, number of sets. Power of two, >=2.
- LINE_BITS, 256, line width in bits. Power of two, >=64.
- ADDR_W, 32, byte address width.
- CNT_W, 32, width of the performance counters.
- Derived widths:
  - OFF = log2(LINE_BITS/8)
  - IDX = log2(SETS)
  - TAG = ADDR_W-IDX-OFF
  - address fields are tag=[ADDR_W-1:IDX+OFF], index=[IDX+OFF-1:OFF], word=[OFF-1:2]

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- read_a  in  1  fetch request; held high until resp_a.
- address_a  in  ADDR_W  byte address; stable while read_a is high. Bits [1:0] are ignored.
- rdata_a  out  32  fetched word; valid when resp_a is high, 0 otherwise.
- resp_a  out  1  one-cycle response strobe.
- flush  in  1  single-cycle pulse that invalidates every line.
- pmem_read_a  out  1  line fill request; held until pmem_resp_a.
- pmem_addr_a  out  ADDR_W  line-aligned fill address (offset bits 0).
- pmem_rdata_a  in  LINE_BITS  fill data; valid with pmem_resp_a.
- pmem_resp_a  in  1  fill complete, one cycle.
- hit_count  out  CNT_W  saturating hit counter.
- miss_count  out  CNT_W  saturating miss counter.

Behaviour:
- Storage: per set and way, a valid bit, a TAG-bit tag and a LINE_BITS data line, all in flops. Per set, a log2(WAYS)-bit round-robin pointer.
- Reset (asynchronous, rst_n=0):
  - all valid bits 0, all pointers 0, state IDLE;
  - resp_a=0, pmem_read_a=0, pmem_addr_a=0, rdata_a=0;
  - counters 0, flush_pend=0, replay=0.
  - Tag and data contents are don't-care.
  - Reset during FILL abandons the fill immediately; pmem_read_a drops asynchronously.
- FSM states: IDLE and FILL.
- IDLE, read_a=1, hit (any way valid with a matching tag in the indexed set):
  - resp_a=1 combinationally in the same cycle;
  - rdata_a = word[word] of the hitting line;
  - hit_count increments unless replay=1;
  - replay clears.
  - Hit latency is 0 cycles after request.
- IDLE, read_a=1, miss:
  - go to FILL next cycle; miss_count increments once;
  - the victim is latched: the lowest-numbered invalid way, else the set's pointer;
  - pmem_addr_a is registered as the line-aligned address.
- FILL:
  - pmem_read_a=1 and pmem_addr_a held constant; resp_a=0.
  - On pmem_resp_a, write data and tag into the victim. Set valid=!flush_pend.
  - If the victim was chosen by the pointer, advance the set's pointer (mod WAYS).
  - Clear flush_pend, set replay=1, return to IDLE.
  - The next IDLE cycle hits and responds.
  - Miss latency = pmem latency + 2 cycles.
- Flush:
  - In IDLE, all valid bits clear at the next edge and pointers reset to 0.
  - A read in the same cycle as flush is still evaluated against the pre-flush state; if it hits, it responds.
  - In FILL, flush sets flush_pend and clears all valid bits at the next edge. The in-flight line installs as invalid, so the replay misses and refetches.
- Counters:
  - saturate at all-ones and never wrap;
  - cleared only by reset.
- Exactly one way may match. Duplicate tags in a set cannot arise, because fills occur only on a miss.
- With WAYS=1, the pointer is absent and the victim is always way 0.
- pmem_read_a never asserts outside FILL.
- resp_a never asserts in FILL.

Test Plan:
- Defaults.
- Cold miss read_a=1, address_a=0x0000_0044:
  - pmem_addr_a=0x0000_0040 and pmem_read_a=1 one cycle later;
  - after 5 cycles, return a line with word1=0xDEADBEEF;
  - resp_a must assert 1 cycle after pmem_resp_a with rdata_a=0xDEADBEEF, miss_count=1, hit_count=0.
- Follow-up read of 0x0000_0048 -> resp_a the same cycle, rdata_a=word2, hit_count=1.
- Conflict in set 0:
  - fill 0x000, 0x100 (ways 0 and 1), then 0x200, which evicts way 0 (pointer 0->1);
  - read 0x100 -> hit;
  - read 0x000 -> miss, evicting way 1;
  - miss_count=4.
- Flush in IDLE after filling 0x040:
  - pulse flush, then read 0x044 -> miss and pmem_read_a reasserts;
  - miss_count increments.
- Flush mid-FILL:
  - pulse flush 2 cycles into a fill of 0x080, then complete the fill;
  - the replay must miss again, with a second pmem_read_a to 0x080.
- Reset and saturation:
  - assert rst_n=0 mid-fill -> pmem_read_a=0 immediately; a subsequent read misses.
  - With CNT_W=4, 20 consecutive hits -> hit_count=15.

Source files
------------

// File: rtl/instr_cache_assoc_if.sv
// instr_cache_assoc_if: fetch-side request/response and line-wide fill port of the I-cache.
interface instr_cache_assoc_if #(
   parameter int ADDR_W = 32,
   parameter int LINE_BITS = 256
) ();
   logic                 read_a;
   logic [ADDR_W-1:0]    address_a;
   logic [31:0]          rdata_a;
   logic                 resp_a;
   logic                 pmem_read_a;
   logic [ADDR_W-1:0]    pmem_addr_a;
   logic [LINE_BITS-1:0] pmem_rdata_a;
   logic                 pmem_resp_a;
   modport master (
      output read_a, address_a, pmem_rdata_a, pmem_resp_a,
      input  rdata_a, resp_a, pmem_read_a, pmem_addr_a
   );
   modport slave (
      input  read_a, address_a, pmem_rdata_a, pmem_resp_a,
      output rdata_a, resp_a, pmem_read_a, pmem_addr_a
   );
endinterface

// File: rtl/instr_cache_assoc.sv
// instr_cache_assoc: read-only N-way set-associative I-cache with whole-cache flush,
// invalid-first/round-robin replacement and saturating hit/miss counters.
module instr_cache_assoc #(
   parameter int WAYS = 2,
   parameter int SETS = 8,
   parameter int LINE_BITS = 256,
   parameter int ADDR_W = 32,
   parameter int CNT_W = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   instr_cache_assoc_if.slave bus,
   input  logic               flush,
   output logic [CNT_W-1:0]   hit_count,
   output logic [CNT_W-1:0]   miss_count
);
   localparam int OFF = $clog2(LINE_BITS/8);
   localparam int IDX = $clog2(SETS);
   localparam int TAG = ADDR_W-IDX-OFF;
   localparam int WB = WAYS > 1 ? $clog2(WAYS) : 1;
   typedef enum logic {IDLE, FILL} state_t;
   state_t state, state_nx;
   logic [WAYS-1:0] valid [SETS];
   logic [TAG-1:0] tags [SETS][WAYS];
   logic [LINE_BITS-1:0] data [SETS][WAYS];
   logic [WB-1:0] ptr [SETS];
   logic [WB-1:0] hit_way, inv_way, victim;
   logic hit, has_inv, vic_by_ptr, flush_pend, replay;
   logic [ADDR_W-1:0] fill_addr;
   logic [IDX-1:0] idx, fidx;
   logic [TAG-1:0] tag, ftag;
   logic [OFF-3:0] word;
   logic unused;
   assign idx = bus.address_a[IDX+OFF-1:OFF];
   assign tag = bus.address_a[ADDR_W-1:IDX+OFF];
   assign word = bus.address_a[OFF-1:2];
   assign fidx = fill_addr[IDX+OFF-1:OFF];
   assign ftag = fill_addr[ADDR_W-1:IDX+OFF];
   assign unused = ^bus.address_a[1:0];
   assign bus.pmem_addr_a = fill_addr;
   assign bus.rdata_a = bus.resp_a ? data[idx][hit_way][{word, 5'b0} +: 32] : '0;
   // Descending scan so the lowest-numbered invalid way wins.
   always_comb begin
      hit = 1'b0;
      hit_way = '0;
      has_inv = 1'b0;
      inv_way = '0;
      for (int w = WAYS-1; w >= 0; w--) begin
         if (valid[idx][w] && tags[idx][w] == tag) begin
            hit = 1'b1;
            hit_way = WB'(w);
         end
         if (!valid[idx][w]) begin
            has_inv = 1'b1;
            inv_way = WB'(w);
         end
      end
   end
   always_comb begin
      state_nx = state;
      bus.resp_a = 1'b0;
      bus.pmem_read_a = 1'b0;
      if (state == IDLE) begin
         bus.resp_a = bus.read_a && hit;
         state_nx = bus.read_a && !hit ? FILL : IDLE;
      end else begin
         bus.pmem_read_a = 1'b1;
         state_nx = bus.pmem_resp_a ? IDLE : FILL;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         fill_addr <= '0;
         victim <= '0;
         vic_by_ptr <= 1'b0;
         flush_pend <= 1'b0;
         replay <= 1'b0;
         hit_count <= '0;
         miss_count <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid[s] <= '0;
            ptr[s] <= '0;
         end
      end else begin
         state <= state_nx;
         if (state == IDLE) begin
            if (bus.read_a && hit) begin
               replay <= 1'b0;
               if (!replay && hit_count != '1) hit_count <= hit_count + 1'b1;
            end
            if (bus.read_a && !hit) begin
               if (miss_count != '1) miss_count <= miss_count + 1'b1;
               victim <= has_inv ? inv_way : ptr[idx];
               vic_by_ptr <= !has_inv;
               fill_addr <= {bus.address_a[ADDR_W-1:OFF], OFF'(0)};
            end
            if (flush)
               for (int s = 0; s < SETS; s++) begin
                  valid[s] <= '0;
                  ptr[s] <= '0;
               end
         end else begin
            if (flush) begin
               flush_pend <= 1'b1;
               for (int s = 0; s < SETS; s++) valid[s] <= '0;
            end
            // A flush seen at any point of the fill leaves the arriving line invalid.
            if (bus.pmem_resp_a) begin
               valid[fidx][victim] <= !(flush_pend || flush);
               if (vic_by_ptr && WAYS > 1) ptr[fidx] <= ptr[fidx] + 1'b1;
               flush_pend <= 1'b0;
               replay <= 1'b1;
            end
         end
      end
   end
   always_ff @(posedge clk)
      if (state == FILL && bus.pmem_resp_a) begin
         tags[fidx][victim] <= ftag;
         data[fidx][victim] <= bus.pmem_rdata_a;
      end
endmodule

// File: tb/tb_instr_cache_assoc.sv
// tb_instr_cache_assoc: scoreboard bench; a line-residency model predicts hit/miss, data comes
// from a synthetic memory, and a monitor checks each response against the queued expectation.
module tb_instr_cache_assoc;
   localparam int WAYS = 2, SETS = 8, LB = 256, CW = 4, CMAX = 15, LBYTES = LB/8;
   logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
   logic [CW-1:0] hit_count, miss_count;
   instr_cache_assoc_if #(.ADDR_W(32), .LINE_BITS(LB)) bus ();
   instr_cache_assoc #(.WAYS(WAYS), .SETS(SETS), .LINE_BITS(LB), .ADDR_W(32), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .flush(flush),
      .hit_count(hit_count), .miss_count(miss_count)
   );
   always #5 clk = ~clk;

   typedef struct { logic [31:0] rdata; int hits; int misses; int fills; } exp_t;
   exp_t sbq[$];
   exp_t mon_e;
   int errors = 0, checks = 0;
   int lat_cfg = 3;
   logic [31:0] fill_exp = '0;
   logic [31:0] ovr [logic [31:0]];
   logic [LB-1:0] fill_line;
   bit m_val [SETS][WAYS];
   int m_tag [SETS][WAYS];
   int m_ptr [SETS];
   int m_hits = 0, m_misses = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      return ovr.exists(w) ? ovr[w] : (w * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
   endfunction

   function automatic int m_set(input logic [31:0] a);
      return int'((a / LBYTES) % SETS);
   endfunction

   function automatic int m_tagof(input logic [31:0] a);
      return int'(a / (LBYTES * SETS));
   endfunction

   function automatic bit m_hit(input logic [31:0] a);
      for (int w = 0; w < WAYS; w++)
         if (m_val[m_set(a)][w] && m_tag[m_set(a)][w] == m_tagof(a)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int m_victim(input int s, output bit by_ptr);
      by_ptr = 1'b0;
      for (int w = 0; w < WAYS; w++) if (!m_val[s][w]) return w;
      by_ptr = 1'b1;
      return m_ptr[s];
   endfunction

   function automatic void m_put(input logic [31:0] a, input int w, input bit by_ptr, input bit v);
      m_val[m_set(a)][w] = v;
      m_tag[m_set(a)][w] = m_tagof(a);
      if (by_ptr) m_ptr[m_set(a)] = (m_ptr[m_set(a)] + 1) % WAYS;
   endfunction

   function automatic void m_flush(input bit idle);
      for (int s = 0; s < SETS; s++) begin
         for (int w = 0; w < WAYS; w++) m_val[s][w] = 1'b0;
         if (idle) m_ptr[s] = 0;
      end
   endfunction

   function automatic int sat(input int x);
      return x > CMAX ? CMAX : x;
   endfunction

   // fk: cycle (relative to issue) at which flush pulses; -1 for none.
   task automatic do_read(input logic [31:0] a, input int fk, input int l);
      exp_t e;
      bit bp;
      int w;
      int i;
      bit done;
      e.rdata = mem_word(a);
      if (m_hit(a)) begin
         e.fills = 0;
         e.hits = m_hits;
         e.misses = m_misses;
         m_hits = sat(m_hits + 1);
         if (fk == 0) m_flush(1'b1);
      end else begin
         m_misses = sat(m_misses + 1);
         w = m_victim(m_set(a), bp);
         e.fills = 1;
         if (fk == 0) begin
            m_flush(1'b1);
            m_put(a, w, bp, 1'b1);
         end else if (fk > 0) begin
            m_put(a, w, bp, 1'b0);
            m_flush(1'b0);
            m_misses = sat(m_misses + 1);
            w = m_victim(m_set(a), bp);
            m_put(a, w, bp, 1'b1);
            e.fills = 2;
         end else m_put(a, w, bp, 1'b1);
         e.hits = m_hits;
         e.misses = m_misses;
      end
      sbq.push_back(e);
      lat_cfg = l;
      fill_exp = a & ~32'(LBYTES-1);
      @(posedge clk);
      #1;
      bus.read_a = 1'b1;
      bus.address_a = a;
      flush = (fk == 0);
      i = 0;
      done = 1'b0;
      while (!done) begin
         @(negedge clk);
         if (bus.resp_a) done = 1'b1;
         else if (i >= 300) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout: addr %h got no resp_a expected one within 300 cycles", a);
            done = 1'b1;
         end
         @(posedge clk);
         #1;
         i++;
         flush = !done && fk == i;
      end
      bus.read_a = 1'b0;
      flush = 1'b0;
   endtask

   task automatic pulse_flush();
      @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      m_flush(1'b1);
   endtask

   task automatic m_reset();
      m_flush(1'b1);
      m_hits = 0;
      m_misses = 0;
      sbq.delete();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst_n = 1'b0;
      bus.read_a = 1'b0;
      flush = 1'b0;
      m_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Fill-port responder: answers each line request after lat_cfg cycles.
   initial begin
      bus.pmem_resp_a = 1'b0;
      bus.pmem_rdata_a = '0;
      forever begin
         @(negedge clk);
         if (rst_n && bus.pmem_read_a) begin
            chk("pmem_addr", bus.pmem_addr_a, fill_exp);
            for (int k = 0; k < lat_cfg; k++) @(posedge clk);
            #1;
            if (bus.pmem_read_a) begin
               for (int j = 0; j < LB/32; j++) fill_line[32*j +: 32] = mem_word(bus.pmem_addr_a + 32'(4*j));
               bus.pmem_rdata_a = fill_line;
               bus.pmem_resp_a = 1'b1;
               @(posedge clk);
               #1 bus.pmem_resp_a = 1'b0;
            end
         end
      end
   end

   int cyc = 0, nfill = 0;
   bit in_req = 1'b0, prev_presp = 1'b0, prev_pread = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         in_req = 1'b0;
         prev_presp = 1'b0;
         prev_pread = 1'b0;
      end else begin
         if (bus.read_a && !in_req) begin
            in_req = 1'b1;
            cyc = 0;
            nfill = 0;
         end else if (in_req) cyc++;
         if (bus.pmem_read_a && !prev_pread && in_req) nfill++;
         chk("resp_and_pmem_read", 32'(bus.resp_a & bus.pmem_read_a), 0);
         if (!bus.resp_a) chk("rdata_without_resp", bus.rdata_a, 0);
         else if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: got resp_a=1 expected none queued");
         end else begin
            mon_e = sbq.pop_front();
            chk("rdata", bus.rdata_a, mon_e.rdata);
            chk("hit_count", 32'(hit_count), mon_e.hits);
            chk("miss_count", 32'(miss_count), mon_e.misses);
            chk("fill_count", nfill, mon_e.fills);
            if (mon_e.fills == 0) chk("hit_latency", cyc, 0);
            else chk("resp_after_pmem_resp", 32'(prev_presp), 1);
         end
         if (bus.resp_a) in_req = 1'b0;
         prev_presp = bus.pmem_resp_a;
         prev_pread = bus.pmem_read_a;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation got stuck, expected completion");
      $fatal(1);
   end

   initial begin
      logic [31:0] a;
      int l, fk, r;
      bus.read_a = 1'b0;
      bus.address_a = '0;
      m_reset();
      #12;
      chk("rst_resp", 32'(bus.resp_a), 0);
      chk("rst_pmem_read", 32'(bus.pmem_read_a), 0);
      chk("rst_pmem_addr", bus.pmem_addr_a, 0);
      chk("rst_rdata", bus.rdata_a, 0);
      chk("rst_hits", 32'(hit_count), 0);
      chk("rst_misses", 32'(miss_count), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      ovr[32'h44] = 32'hDEAD_BEEF;
      do_read(32'h44, -1, 5);
      do_read(32'h48, -1, 5);
      do_reset();
      do_read(32'h000, -1, 2);
      do_read(32'h100, -1, 2);
      do_read(32'h200, -1, 2);
      do_read(32'h100, -1, 2);
      do_read(32'h000, -1, 2);
      @(posedge clk);
      #1 chk("conflict_misses", 32'(miss_count), 4);
      do_reset();
      do_read(32'h40, -1, 3);
      pulse_flush();
      do_read(32'h44, -1, 3);
      do_read(32'h80, 2, 5);
      @(posedge clk);
      #1;
      bus.read_a = 1'b1;
      bus.address_a = 32'hC0;
      fill_exp = 32'hC0;
      lat_cfg = 8;
      repeat (3) @(posedge clk);
      #2 chk("pmem_read_before_reset", 32'(bus.pmem_read_a), 1);
      rst_n = 1'b0;
      #1 chk("pmem_read_on_reset", 32'(bus.pmem_read_a), 0);
      bus.read_a = 1'b0;
      m_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      do_read(32'hC4, -1, 3);
      do_reset();
      do_read(32'h0, -1, 2);
      for (int i = 0; i < 20; i++) do_read(32'(4 * (i % 8)), -1, 1);
      @(posedge clk);
      #1 chk("hit_saturation", 32'(hit_count), 15);
      do_reset();
      for (int i = 0; i < 250; i++) begin
         a = 32'((($urandom % 4) << 8) | (($urandom % SETS) << 5) | (($urandom % 8) << 2));
         l = $urandom_range(1, 6);
         r = $urandom % 10;
         fk = r == 0 ? 0 : r == 1 ? $urandom_range(1, l) : -1;
         do_read(a, fk, l);
         if ($urandom % 20 == 0) pulse_flush();
      end
      repeat (3) @(posedge clk);
      chk("scoreboard_drained", sbq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
